// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for fifo_stream_reader.
// master: the reader adapter; slave: the FIFO/consumer side.
interface fifo_stream_reader_if #(
  parameter int unsigned B = 8
);
  logic         fifo_empty;
  logic [B-1:0] fifo_r_data;
  logic         fifo_rd;
  logic         m_valid;
  logic         m_ready;
  logic [B-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_r_data,
    output fifo_rd,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_r_data,
    input  fifo_rd,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through FIFO into a registered valid/ready stream via a 2-entry skid buffer.
// Optional delivered-word counter on rd_count is compiled in with FIFO_RD_CNT_EN.
module fifo_stream_reader #(
  parameter int unsigned B = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_stream_reader_if.master bus
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [15:0]          rd_count
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e       state_q;
  logic [B-1:0] main_q;
  logic [B-1:0] skid_q;
  logic         rd_c;
  logic         take_c;

  // Read strobe depends only on registered state, so m_ready never reaches fifo_rd.
  assign rd_c        = reset & ~bus.fifo_empty & (state_q != S_TWO);
  assign take_c      = (state_q != S_EMPTY) & bus.m_ready;

  assign bus.fifo_rd = rd_c;
  assign bus.m_valid = (state_q != S_EMPTY);
  assign bus.m_data  = main_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (rd_c) begin
            state_q <= S_ONE;
            main_q  <= bus.fifo_r_data;
          end
        end
        S_ONE: begin
          if (rd_c && take_c) begin
            main_q  <= bus.fifo_r_data;
          end else if (rd_c) begin
            state_q <= S_TWO;
            skid_q  <= bus.fifo_r_data;
          end else if (take_c) begin
            state_q <= S_EMPTY;
          end
        end
        S_TWO: begin
          // Skid word moves up; no pop happens while both slots are full.
          if (take_c) begin
            state_q <= S_ONE;
            main_q  <= skid_q;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

`ifdef FIFO_RD_CNT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] rd_count_q;

  // Counts accepted words; wraps naturally at 2^16.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count_q <= '0;
    end else if (take_c) begin
      rd_count_q <= rd_count_q + CNT_W'(1);
    end
  end

  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: a queue-based FIFO and an occupancy/order scoreboard.
module tb_fifo_stream_reader;
  localparam int unsigned B = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [B-1:0] fifo_q[$];
  logic [B-1:0] exp_q[$];
  int unsigned  ntake = 0;
  logic [15:0]  cnt_model = '0;

  fifo_stream_reader_if #(.B(B)) bus ();
`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_count;
`endif

  fifo_stream_reader #(.B(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count (rd_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: present FIFO head, check outputs against the scoreboard, advance the model.
  task automatic cycle(output logic rd_o, output logic v_o, output logic [B-1:0] d_o);
    logic         rst_now;
    logic         exp_rd;
    logic         tk;
    int           occ;
    logic [B-1:0] w;
    bus.fifo_empty  = (fifo_q.size() == 0);
    bus.fifo_r_data = (fifo_q.size() != 0) ? fifo_q[0] : {B{1'bx}};
    #1;
    rst_now = reset;
    occ     = exp_q.size();
    rd_o    = bus.fifo_rd;
    v_o     = bus.m_valid;
    d_o     = bus.m_data;
    exp_rd  = rst_now && (fifo_q.size() != 0) && (occ < 2);
    check("m_valid", 32'(v_o), 32'(occ != 0));
    if (occ != 0) check("m_data", 32'(d_o), 32'(exp_q[0]));
    check("fifo_rd", 32'(rd_o), 32'(exp_rd));
`ifdef FIFO_RD_CNT_EN
    check("rd_count", 32'(rd_count), 32'(cnt_model));
`endif
    tk = v_o & bus.m_ready;
    @(posedge clk);
    @(negedge clk);
    if (!rst_now) begin
      exp_q.delete();
      cnt_model = '0;
      if (rd_o && fifo_q.size() != 0) void'(fifo_q.pop_front());
    end else begin
      if (tk && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        cnt_model = cnt_model + 16'd1;
        ntake++;
      end
      if (rd_o && fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        exp_q.push_back(w);
      end
    end
  endtask

  initial begin
    logic         r;
    logic         v;
    logic [B-1:0] d;
    logic         rd_log[16];
    logic         v_log[16];
    logic [B-1:0] d_log[16];
    int           npop;
    int unsigned  start;
    int           sent;
    logic [B-1:0] head;

    reset           = 1'b0;
    bus.m_ready     = 1'b0;
    bus.fifo_empty  = 1'b1;
    bus.fifo_r_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset held with a non-empty FIFO
    fifo_q.push_back(8'h55);
    bus.m_ready = 1'b1;
    repeat (3) begin
      cycle(r, v, d);
      check("rst_m_data", 32'(d), 32'h0);
    end
    fifo_q.delete();

    // Streaming 0x01..0x08 with ready held high
    for (int i = 1; i <= 8; i++) fifo_q.push_back(B'(i));
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(r, v, d);
      rd_log[i] = r; v_log[i] = v; d_log[i] = d;
    end
    check("stream_first_rd", 32'(rd_log[0]), 32'h1);
    for (int i = 0; i < 12; i++) begin
      check("stream_valid", 32'(v_log[i]), 32'(i >= 1 && i <= 8));
      if (i >= 1 && i <= 8) check("stream_data", 32'(d_log[i]), 32'(i));
    end

    // Backpressure: ready low from the start
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(B'(8'hA0 + i));
    npop = 0;
    repeat (6) begin
      cycle(r, v, d);
      if (r) npop++;
    end
    check("bp_pops", 32'(npop), 32'd2);
    check("bp_hold_valid", 32'(v), 32'h1);
    check("bp_hold_data", 32'(d), 32'hA0);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(r, v, d);
      v_log[i] = v; d_log[i] = d;
    end
    for (int i = 0; i < 6; i++) begin
      check("bp_drain_valid", 32'(v_log[i]), 32'(i < 4));
      if (i < 4) check("bp_drain_data", 32'(d_log[i]), 32'(8'hA0 + i));
    end

    // 100 random words, random ready, FIFO fed irregularly
    start = ntake;
    sent  = 0;
    for (int n = 0; n < 3000 && (ntake - start) < 100; n++) begin
      if (sent < 100 && $urandom_range(0, 3) != 0) begin
        fifo_q.push_back(B'($urandom));
        sent++;
      end
      bus.m_ready = 1'($urandom_range(0, 1));
      cycle(r, v, d);
    end
    check("rand_delivered", ntake - start, 32'd100);
    check("rand_leftover", 32'(exp_q.size() + fifo_q.size()), 32'd0);

    // Reset while both slots are full
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(B'(8'hB0 + i));
    repeat (3) cycle(r, v, d);
    check("mid_pre_valid", 32'(v), 32'h1);
    reset = 1'b0;
    cycle(r, v, d);
    reset = 1'b1;
    head = fifo_q[0];
    bus.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(r, v, d);
      v_log[i] = v; d_log[i] = d;
    end
    check("mid_post_valid", 32'(v_log[0]), 32'h0);
    check("mid_first_valid", 32'(v_log[1]), 32'h1);
    check("mid_first_word", 32'(d_log[1]), 32'(head));

`ifdef FIFO_RD_CNT_EN
    // Counter wrap after 65537 takes
    reset = 1'b0;
    cycle(r, v, d);
    reset = 1'b1;
    fifo_q.delete();
    start = ntake;
    bus.m_ready = 1'b1;
    for (int n = 0; n < 70000 && (ntake - start) < 65537; n++) begin
      if (fifo_q.size() < 2) fifo_q.push_back(B'($urandom));
      cycle(r, v, d);
    end
    bus.m_ready = 1'b0;
    cycle(r, v, d);
    check("cnt_wrap", 32'(rd_count), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Consumer-side adapter for the synchronous FIFO. It drains the FIFO's rd/empty/r_data read port, which is first-word-fall-through, and presents the words as a registered valid/ready stream. A two-entry skid buffer decouples the stream's backpressure from the FIFO read strobe, so `fifo_rd` never depends combinationally on `m_ready`. It sits between the FIFO and any downstream stream consumer, and it sustains 1 word/cycle.

## Interface
- `B`, default 8: data word width in bits.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_r_data`  in  B  FIFO head word; valid whenever `fifo_empty`=0.
- `fifo_rd`  out  1  FIFO read/pop strobe; the head is consumed at the clock edge where this is 1.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  B  output word.
- `rd_count`  out  16  words delivered; present only with `FIFO_RD_CNT_EN`.

## Operation
- Storage:
  - main register `main_q` drives `m_data`.
  - skid register `skid_q` holds one extra word.
- State register, one of three states:
  - S_EMPTY: 0 words held.
  - S_ONE: `main_q` holds a word.
  - S_TWO: both `main_q` and `skid_q` hold words.
- Derived signals:
  - `m_valid` = (state != S_EMPTY), decoded from the state register only.
  - `fifo_rd` = `reset` & ~`fifo_empty` & (state != S_TWO). This is purely a function of registered state and `fifo_empty`.
  - take = `m_valid` & `m_ready`.
- Transitions, where rd = `fifo_rd`:
  - S_EMPTY, rd → S_ONE, `main_q`<=`fifo_r_data`.
  - S_ONE, rd & take → S_ONE, `main_q`<=`fifo_r_data`.
  - S_ONE, rd & ~take → S_TWO, `skid_q`<=`fifo_r_data`; `main_q` holds.
  - S_ONE, ~rd & take → S_EMPTY.
  - S_TWO, take → S_ONE, `main_q`<=`skid_q`. No FIFO read happens in S_TWO.
  - In every other case, state and data hold.
- Word order is strictly preserved: FIFO order equals stream order.
- Stability rule: while `m_valid`=1 and `m_ready`=0, `m_data` and `m_valid` hold their values unchanged.
- `fifo_r_data` is sampled only on cycles where `fifo_rd`=1. Its value at all other times is ignored, including X.
- `m_ready` asserted while `m_valid`=0 has no effect.

## Timing
- Reset (`reset`=0 at a rising edge):
  - state becomes S_EMPTY.
  - `main_q`, `skid_q`, `m_valid` and `rd_count` become 0.
  - `fifo_rd` is forced to 0 combinationally for as long as `reset`=0.
- Reset mid-operation discards buffered words. Data already popped from the FIFO is lost; this is the required behaviour.
- Latency: if `fifo_empty` falls before edge t while the block is in S_EMPTY, `fifo_rd`=1 in the cycle before edge t, and `m_valid`=1 with the word on `m_data` from edge t.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, one word transfers per cycle indefinitely. The block stays in S_ONE.
- Backpressure:
  - When `m_ready` drops, at most one additional word is popped, into the skid register, and then `fifo_rd`=0.
  - After `m_ready` returns, the skid word is delivered the next cycle, and FIFO reads resume in that same cycle.
- FIFO empties while in S_ONE or S_TWO: buffered words continue to drain normally and no pop occurs.
- There are no combinational paths from `m_ready` to `fifo_rd`, or from `fifo_r_data` to `m_data`.

## Configuration
- `FIFO_RD_CNT_EN` defined:
  - The `rd_count` port and a 16-bit counter are compiled in.
  - The counter increments by 1 on every take and wraps from 0xFFFF to 0x0000.
  - It resets to 0.
- `FIFO_RD_CNT_EN` undefined: the port and the counter are absent, and all other behaviour is identical.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `fifo_empty`=0 → `fifo_rd`=0, `m_valid`=0, `m_data`=0 throughout.
- **Streaming:** FIFO preloaded with 0x01..0x08, `m_ready`=1 → `m_data` shows 0x01..0x08 on 8 consecutive cycles, the first one cycle after the first `fifo_rd`; then `m_valid`=0.
- **Backpressure:**
  - Stimulus: FIFO holds 0xA0..0xA3, `m_ready`=0 from the start.
  - Required: exactly 2 pops occur; `m_data`=0xA0 is held stable.
  - Then raise `m_ready` → 0xA0, 0xA1, 0xA2, 0xA3 are delivered on consecutive cycles.
- **Toggling ready:** 100 random words with `m_ready` toggling randomly (50%) → output sequence equals input sequence; zero drops and zero duplicates.
- **Reset mid-burst:**
  - Stimulus: assert reset while in S_TWO.
  - Required: the next cycle shows `m_valid`=0.
  - After release, subsequent FIFO words are delivered in order, starting with the FIFO head.
- **Counter wrap (`FIFO_RD_CNT_EN`):** 65537 takes → `rd_count`=1. With the macro undefined, the build elaborates without the port.
